// File: rtl/riscv_trace_encoder.sv
// riscv_trace_encoder
//   Producer end of the instruction-trace path. Watches the retire stream and
//   emits a 64-bit packet only when an off-core decoder cannot infer program
//   flow: sync points, non-inferable discontinuities, traps, count saturation
//   and FIFO overflow. Packets are queued in an internal FIFO.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   trace_en_i        tracing enable
//   retire_valid_i    one instruction retires this cycle
//   retire_pc_i       PC of the retiring instruction
//   retire_instr_i    instruction encoding (upper half ignored when compressed)
//   trap_i            single-cycle trap/interrupt taken
//   trap_cause_i      cause code, valid with trap_i
//   pkt_valid_o       FIFO head valid
//   pkt_ready_i       sink accepts the head
//   pkt_data_o        FIFO head packet (0 when empty)
//   fifo_level_o      FIFO occupancy
//   drop_o            one-cycle pulse: packet discarded, FIFO was full
//
// Packet: [63:61] type, [60:56] 0, [55:50] cause, [49:34] icnt, [33:32] 0, [31:0] pc

module riscv_trace_encoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          trace_en_i,
    input  logic                          retire_valid_i,
    input  logic [31:0]                   retire_pc_i,
    input  logic [31:0]                   retire_instr_i,
    input  logic                          trap_i,
    input  logic [5:0]                    trap_cause_i,
    output logic                          pkt_valid_o,
    input  logic                          pkt_ready_i,
    output logic [63:0]                   pkt_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          drop_o
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    localparam logic [2:0] T_SYNC = 3'd0;
    localparam logic [2:0] T_DISC = 3'd1;
    localparam logic [2:0] T_TRAP = 3'd2;
    localparam logic [2:0] T_CNT  = 3'd3;
    localparam logic [2:0] T_OVF  = 3'd4;

    typedef enum logic [1:0] {ST_SYNC, ST_RUN, ST_OVF} state_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [4:0]  rsv0;
        logic [5:0]  cause;
        logic [15:0] icnt;
        logic [1:0]  rsv1;
        logic [31:0] pc;
    } pkt_t;

    function automatic pkt_t mk_pkt(input logic [2:0] typ, input logic [5:0] cause,
                                    input logic [15:0] icnt, input logic [31:0] pc);
        pkt_t p;
        p.typ   = typ;
        p.rsv0  = '0;
        p.cause = cause;
        p.icnt  = icnt;
        p.rsv1  = '0;
        p.pc    = pc;
        return p;
    endfunction

    // ---------------------------------------------------------------- state
    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [31:0]        exp_pc, exp_pc_n;
    logic               prev_jal, prev_jal_n;
    logic               trap_pend, trap_pend_n;
    logic [5:0]         trap_cause, trap_cause_n;
    logic               drop;

    // ---------------------------------------------------------------- fifo
    pkt_t               mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               full, empty;
    logic               push_req, push, pop;
    pkt_t               push_pkt;

    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign empty = (level == '0);
    // A same-cycle pop never makes room: push uses start-of-cycle occupancy.
    assign push  = push_req && !full;
    assign pop   = !empty && pkt_ready_i;

    // ---------------------------------------------------------------- decode
    logic        is_32b, is_jal;
    logic [31:0] seq_pc;
    logic [15:0] unused_instr_hi;

    assign unused_instr_hi = retire_instr_i[31:16];
    assign is_32b = (retire_instr_i[1:0] == 2'b11);
    // JAL, C.J (101) and C.JAL (001): the target is static, so the decoder
    // can follow the jump without help.
    assign is_jal = (retire_instr_i[6:0] == 7'b1101111) ||
                    ((retire_instr_i[1:0] == 2'b01) &&
                     ((retire_instr_i[15:13] == 3'b101) || (retire_instr_i[15:13] == 3'b001)));
    assign seq_pc = retire_pc_i + (is_32b ? 32'd4 : 32'd2);

    // ---------------------------------------------------------------- fsm
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        exp_pc_n     = exp_pc;
        prev_jal_n   = prev_jal;
        trap_pend_n  = trap_pend;
        trap_cause_n = trap_cause;
        push_req     = 1'b0;
        push_pkt     = '0;
        drop         = 1'b0;

        if (!trace_en_i) begin
            state_n     = ST_SYNC;
            cnt_n       = '0;
            trap_pend_n = 1'b0;
        end else begin
            case (state)
                ST_SYNC: begin
                    if (retire_valid_i) begin
                        push_req   = 1'b1;
                        push_pkt   = mk_pkt(T_SYNC, 6'd0, 16'd0, retire_pc_i);
                        exp_pc_n   = seq_pc;
                        prev_jal_n = is_jal;
                        if (full) begin
                            drop = 1'b1;
                        end else begin
                            cnt_n       = '0;
                            trap_pend_n = 1'b0;
                            state_n     = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (retire_valid_i) begin
                        exp_pc_n   = seq_pc;
                        prev_jal_n = is_jal;
                        if (trap_pend) begin
                            push_req    = 1'b1;
                            push_pkt    = mk_pkt(T_TRAP, trap_cause, cnt, retire_pc_i);
                            trap_pend_n = 1'b0;
                            cnt_n       = '0;
                        end else if ((retire_pc_i != exp_pc) && !prev_jal) begin
                            push_req = 1'b1;
                            push_pkt = mk_pkt(T_DISC, 6'd0, cnt, retire_pc_i);
                            cnt_n    = '0;
                        end else if (cnt == '1) begin
                            push_req = 1'b1;
                            push_pkt = mk_pkt(T_CNT, 6'd0, cnt, retire_pc_i);
                            cnt_n    = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                        if (push_req && full) begin
                            drop    = 1'b1;
                            cnt_n   = '0;
                            state_n = ST_OVF;
                        end
                    end
                end
                ST_OVF: begin
                    if (!full) begin
                        push_req = 1'b1;
                        push_pkt = mk_pkt(T_OVF, 6'd0, 16'd0, 32'd0);
                        state_n  = ST_SYNC;
                    end
                end
                default: state_n = ST_SYNC;
            endcase

            // A new trap is latched after the retire logic so that a trap
            // coinciding with a retire survives for the following retire.
            if (trap_i && (state != ST_OVF)) begin
                trap_pend_n  = 1'b1;
                trap_cause_n = trap_cause_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_SYNC;
            cnt        <= '0;
            exp_pc     <= '0;
            prev_jal   <= 1'b0;
            trap_pend  <= 1'b0;
            trap_cause <= '0;
            drop_o     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            exp_pc     <= exp_pc_n;
            prev_jal   <= prev_jal_n;
            trap_pend  <= trap_pend_n;
            trap_cause <= trap_cause_n;
            drop_o     <= drop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Storage needs no reset: the output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_pkt;
    end

    assign pkt_valid_o  = !empty;
    assign pkt_data_o   = empty ? 64'd0 : mem[rd_ptr];
    assign fifo_level_o = level;

endmodule

// File: tb/tb_riscv_trace_encoder.sv
module tb_riscv_trace_encoder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_en_i = 1'b0;
    logic        retire_valid_i = 1'b0;
    logic [31:0] retire_pc_i = '0;
    logic [31:0] retire_instr_i = '0;
    logic        trap_i = 1'b0;
    logic [5:0]  trap_cause_i = '0;
    logic        pkt_valid_o;
    logic        pkt_ready_i = 1'b0;
    logic [63:0] pkt_data_o;
    logic [3:0]  fifo_level_o;
    logic        drop_o;

    riscv_trace_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trace_en_i     (trace_en_i),
        .retire_valid_i (retire_valid_i),
        .retire_pc_i    (retire_pc_i),
        .retire_instr_i (retire_instr_i),
        .trap_i         (trap_i),
        .trap_cause_i   (trap_cause_i),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_ready_i    (pkt_ready_i),
        .pkt_data_o     (pkt_data_o),
        .fifo_level_o   (fifo_level_o),
        .drop_o         (drop_o)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADDI = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] CJ   = 32'h0000_A001;
    localparam logic [31:0] CNOP = 32'h0000_0001;

    int n_cmp = 0;
    int n_mis = 0;
    logic [63:0] exp_q[$];

    function automatic logic [63:0] pk(input logic [2:0] typ, input logic [5:0] cause,
                                       input logic [15:0] icnt, input logic [31:0] pc);
        return {typ, 5'd0, cause, icnt, 2'd0, pc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Drives one retire for one cycle; returns 1ns after the sampling edge.
    task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                          input logic trap, input logic [5:0] cause);
        retire_valid_i = 1'b1;
        retire_pc_i    = pc;
        retire_instr_i = instr;
        trap_i         = trap;
        trap_cause_i   = cause;
        @(posedge clk); #1;
        retire_valid_i = 1'b0;
        trap_i         = 1'b0;
    endtask

    task automatic trap_only(input logic [5:0] cause);
        trap_i       = 1'b1;
        trap_cause_i = cause;
        @(posedge clk); #1;
        trap_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL %s: %0d packets still expected, 0 required", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && pkt_valid_o && pkt_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL pkt_unexpected: got %h expected none", pkt_data_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (pkt_data_o !== e) begin
                    n_mis++;
                    $display("FAIL pkt: got %h expected %h", pkt_data_o, e);
                end
            end
        end
    end

    initial begin
        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(pkt_valid_o), 64'd0);
        check("rst_level", 64'(fifo_level_o), 64'd0);
        check("rst_data",  pkt_data_o, 64'd0);
        check("rst_drop",  64'(drop_o), 64'd0);
        rst_n = 1'b1;
        trace_en_i = 1'b1;
        @(posedge clk); #1;

        // ---- first retire -> SYNC, visible next cycle
        retire(32'h80, ADDI, 1'b0, 6'd0);
        @(negedge clk);
        check("sync_valid", 64'(pkt_valid_o), 64'd1);
        check("sync_level", 64'(fifo_level_o), 64'd1);
        check("sync_data",  pkt_data_o, pk(3'd0, 6'd0, 16'd0, 32'h80));
        exp_q.push_back(pk(3'd0, 6'd0, 16'd0, 32'h80));
        pkt_ready_i = 1'b1;

        // ---- sequential flow then discontinuity
        retire(32'h84, ADDI, 1'b0, 6'd0);
        retire(32'h88, ADDI, 1'b0, 6'd0);
        retire(32'h8C, ADDI, 1'b0, 6'd0);
        retire(32'h90, BEQ,  1'b0, 6'd0);
        exp_q.push_back(pk(3'd1, 6'd0, 16'd4, 32'h200));
        retire(32'h200, ADDI, 1'b0, 6'd0);

        // ---- JAL suppression (reaching 0x100 is itself a discontinuity)
        exp_q.push_back(pk(3'd1, 6'd0, 16'd0, 32'h100));
        retire(32'h100, JAL, 1'b0, 6'd0);
        retire(32'h400, ADDI, 1'b0, 6'd0);      // inferable, counted
        exp_q.push_back(pk(3'd1, 6'd0, 16'd1, 32'h100));
        retire(32'h100, CJ, 1'b0, 6'd0);
        retire(32'h300, ADDI, 1'b0, 6'd0);      // inferable, counted

        // ---- trap coinciding with a sequential retire
        exp_q.push_back(pk(3'd1, 6'd0, 16'd1, 32'h100));
        retire(32'h100, ADDI, 1'b0, 6'd0);
        retire(32'h104, ADDI, 1'b1, 6'h0B);
        exp_q.push_back(pk(3'd2, 6'h0B, 16'd1, 32'h1C0));
        retire(32'h1C0, ADDI, 1'b0, 6'd0);

        // ---- second trap before retire overwrites the cause
        trap_only(6'h05);
        trap_only(6'h07);
        exp_q.push_back(pk(3'd2, 6'h07, 16'd0, 32'h1C4));
        retire(32'h1C4, ADDI, 1'b0, 6'd0);

        // ---- compressed instruction advances expected PC by 2
        retire(32'h1C8, CNOP, 1'b0, 6'd0);
        retire(32'h1CA, ADDI, 1'b0, 6'd0);
        exp_q.push_back(pk(3'd1, 6'd0, 16'd2, 32'h1D0));
        retire(32'h1D0, ADDI, 1'b0, 6'd0);
        drain("drain_flow");

        // ---- overflow: 9 discontinuities with the sink stalled
        pkt_ready_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(pk(3'd1, 6'd0, 16'd0, 32'(i) << 12));
            retire(32'(i) << 12, ADDI, 1'b0, 6'd0);
        end
        @(negedge clk);
        check("ovf_level8", 64'(fifo_level_o), 64'd8);
        check("ovf_nodrop", 64'(drop_o), 64'd0);
        retire(32'h9000, ADDI, 1'b0, 6'd0);
        @(negedge clk);
        check("ovf_drop",   64'(drop_o), 64'd1);
        check("ovf_level",  64'(fifo_level_o), 64'd8);
        retire(32'hA000, ADDI, 1'b1, 6'h03);    // ignored while in OVF
        @(negedge clk);
        check("ovf_drop_pulse", 64'(drop_o), 64'd0);
        check("ovf_head", pkt_data_o, pk(3'd1, 6'd0, 16'd0, 32'h1000));
        exp_q.push_back(pk(3'd4, 6'd0, 16'd0, 32'd0));
        pkt_ready_i = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        exp_q.push_back(pk(3'd0, 6'd0, 16'd0, 32'hB000));
        retire(32'hB000, ADDI, 1'b0, 6'd0);
        drain("drain_ovf");

        // ---- count saturation
        for (int i = 1; i <= 65535; i++)
            retire(32'hB000 + 32'(i) * 4, ADDI, 1'b0, 6'd0);
        @(negedge clk);
        check("cnt_nopkt", 64'(fifo_level_o), 64'd0);
        exp_q.push_back(pk(3'd3, 6'd0, 16'hFFFF, 32'h4B000));
        retire(32'h4B000, ADDI, 1'b0, 6'd0);
        retire(32'h4B004, ADDI, 1'b0, 6'd0);
        drain("drain_cnt");

        // ---- mid-run reset with a non-empty FIFO
        pkt_ready_i = 1'b0;
        retire(32'h5000, ADDI, 1'b0, 6'd0);     // DISC that reset discards
        @(negedge clk);
        check("prerst_level", 64'(fifo_level_o), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid", 64'(pkt_valid_o), 64'd0);
        check("midrst_level", 64'(fifo_level_o), 64'd0);
        check("midrst_data",  pkt_data_o, 64'd0);
        pkt_ready_i = 1'b1;

        // ---- disable forces resync
        exp_q.push_back(pk(3'd0, 6'd0, 16'd0, 32'h60));
        retire(32'h60, ADDI, 1'b0, 6'd0);
        retire(32'h64, ADDI, 1'b0, 6'd0);
        trace_en_i = 1'b0;
        retire(32'h70, ADDI, 1'b0, 6'd0);       // not traced
        trace_en_i = 1'b1;
        exp_q.push_back(pk(3'd0, 6'd0, 16'd0, 32'h74));
        retire(32'h74, ADDI, 1'b0, 6'd0);
        drain("drain_en");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
